// File: rtl/data_store_tx.sv
// Transmit-side word buffer: collects 16-bit words, then replays the whole frame
// as a gap-free stream of N-bit symbols, most significant symbol first.
module data_store_tx #(
  parameter int N     = 4,
  parameter int DEPTH = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [15:0]                wr_data,
  input  logic                       wr_valid,
  input  logic                       send_request,
  output logic                       axiov,
  output logic [N-1:0]               axiod,
  output logic                       busy,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int SPW = 16 / N;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int SW  = $clog2(SPW);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          full_q;
  logic          busy_q;
  logic          valid_q;
  logic [15:0]   sh_q;
  logic [15:0]   rd_data_q;
  logic [AW-1:0] word_addr_q;
  logic [AW-1:0] rd_addr_q;
  logic [SW-1:0] sym_idx_q;
  logic [15:0]   mem_q [DEPTH];
  logic          wr_accept_s;
  logic          sym_wrap_s;
  logic          last_sym_s;

  // Write acceptance, post-write occupancy and end-of-frame detection.
  always_comb begin
    wr_accept_s = (state_q == FILL) && wr_valid && (count_q < CW'(DEPTH));
    count_d     = count_q + (wr_accept_s ? CW'(1) : CW'(0));
    sym_wrap_s  = (sym_idx_q == SW'(SPW - 1));
    last_sym_s  = valid_q && sym_wrap_s && (CW'(word_addr_q) == count_q - CW'(1));
  end

  // Frame memory: write at the fill pointer, registered read at the prefetch pointer.
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      mem_q[count_q[AW-1:0]] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr_q];
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FILL;
      count_q     <= '0;
      full_q      <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      sh_q        <= '0;
      word_addr_q <= '0;
      rd_addr_q   <= '0;
      sym_idx_q   <= '0;
    end else begin
      case (state_q)
        FILL: begin
          count_q   <= count_d;
          full_q    <= (count_d == CW'(DEPTH));
          rd_addr_q <= '0;
          if (send_request && (count_d != '0)) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          // Word 0 is being read now; point the read port at word 1 for prefetch.
          rd_addr_q <= AW'(1);
          state_q   <= SEND;
        end
        SEND: begin
          if (last_sym_s) begin
            state_q     <= FILL;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            sh_q        <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            word_addr_q <= '0;
            rd_addr_q   <= '0;
            sym_idx_q   <= '0;
          end else if (!valid_q || sym_wrap_s) begin
            valid_q   <= 1'b1;
            sh_q      <= rd_data_q;
            sym_idx_q <= '0;
            if (valid_q) begin
              word_addr_q <= word_addr_q + AW'(1);
              rd_addr_q   <= rd_addr_q + AW'(1);
            end
          end else begin
            sh_q      <= sh_q << N;
            sym_idx_q <= sym_idx_q + SW'(1);
          end
        end
        default: begin
          state_q <= FILL;
        end
      endcase
    end
  end

  assign axiov = valid_q;
  assign axiod = sh_q[15 -: N];
  assign busy  = busy_q;
  assign full  = full_q;
  assign count = count_q;

endmodule

// File: tb/tb_data_store_tx.sv
// Scoreboard bench for data_store_tx: a word-level model predicts the symbol stream
// and a negedge monitor checks every symbol the DUTs emit.
`timescale 1ns/1ps
module tb_data_store_tx;
  localparam int N_A = 4;
  localparam int DEPTH_A = 256;
  localparam int N_B = 2;
  localparam int DEPTH_B = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [15:0] wr_data_a = '0, wr_data_b = '0;
  logic wr_valid_a = 1'b0, wr_valid_b = 1'b0, send_a = 1'b0, send_b = 1'b0;
  logic axiov_a, axiov_b, busy_a, busy_b, full_a, full_b;
  logic [N_A-1:0] axiod_a;
  logic [N_B-1:0] axiod_b;
  logic [$clog2(DEPTH_A+1)-1:0] count_a;
  logic [$clog2(DEPTH_B+1)-1:0] count_b;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] store_a[$], store_b[$];
  int exp_a[$], exp_b[$];

  always #5 clk = ~clk;

  data_store_tx #(.N(N_A), .DEPTH(DEPTH_A)) u_a (
    .clk(clk), .rst(rst), .wr_data(wr_data_a), .wr_valid(wr_valid_a),
    .send_request(send_a), .axiov(axiov_a), .axiod(axiod_a), .busy(busy_a),
    .full(full_a), .count(count_a));

  data_store_tx #(.N(N_B), .DEPTH(DEPTH_B)) u_b (
    .clk(clk), .rst(rst), .wr_data(wr_data_b), .wr_valid(wr_valid_b),
    .send_request(send_b), .axiov(axiov_b), .axiod(axiod_b), .busy(busy_b),
    .full(full_b), .count(count_b));

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Symbol s (0 = first sent) of word w for an n-bit link.
  function automatic int sym_of(input logic [15:0] w, input int n, input int s);
    return (int'(w) >> (16 - n * (s + 1))) & ((1 << n) - 1);
  endfunction

  function automatic void mdl_write(input int sel, input logic [15:0] d);
    if (sel == 0) begin
      if (store_a.size() < DEPTH_A) store_a.push_back(d);
    end else begin
      if (store_b.size() < DEPTH_B) store_b.push_back(d);
    end
  endfunction

  function automatic int mdl_send(input int sel);
    int nsym = 0;
    if (sel == 0) begin
      foreach (store_a[i])
        for (int s = 0; s < 16 / N_A; s++) begin
          exp_a.push_back(sym_of(store_a[i], N_A, s));
          nsym++;
        end
      store_a.delete();
    end else begin
      foreach (store_b[i])
        for (int s = 0; s < 16 / N_B; s++) begin
          exp_b.push_back(sym_of(store_b[i], N_B, s));
          nsym++;
        end
      store_b.delete();
    end
    return nsym;
  endfunction

  function automatic int mdl_size(input int sel);
    return (sel == 0) ? store_a.size() : store_b.size();
  endfunction
  function automatic int mdl_depth(input int sel);
    return (sel == 0) ? DEPTH_A : DEPTH_B;
  endfunction
  function automatic int get_axiov(input int sel);
    return (sel == 0) ? int'(axiov_a) : int'(axiov_b);
  endfunction
  function automatic int get_busy(input int sel);
    return (sel == 0) ? int'(busy_a) : int'(busy_b);
  endfunction
  function automatic int get_full(input int sel);
    return (sel == 0) ? int'(full_a) : int'(full_b);
  endfunction
  function automatic int get_count(input int sel);
    return (sel == 0) ? int'(count_a) : int'(count_b);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic v, input logic [15:0] d, input logic s);
    if (sel == 0) begin
      wr_valid_a = v; wr_data_a = d; send_a = s;
    end else begin
      wr_valid_b = v; wr_data_b = d; send_b = s;
    end
  endtask

  task automatic write_word(input int sel, input logic [15:0] d);
    drive(sel, 1'b1, d, 1'b0);
    tick();
    drive(sel, 1'b0, 16'h0, 1'b0);
    mdl_write(sel, d);
    check("count_after_write", get_count(sel), mdl_size(sel));
    check("full_after_write", get_full(sel), int'(mdl_size(sel) == mdl_depth(sel)));
  endtask

  task automatic start_send(input int sel, input logic has_wr, input logic [15:0] d,
                            output int nsym);
    drive(sel, has_wr, d, 1'b1);
    tick();
    drive(sel, 1'b0, 16'h0, 1'b0);
    if (has_wr) mdl_write(sel, d);
    nsym = mdl_send(sel);
  endtask

  // Timing and length of one frame; poke >= 0 issues a write+request mid-frame.
  task automatic check_frame(input int sel, input int nsym, input int poke);
    int len = 0;
    check("busy_after_request", get_busy(sel), int'(nsym > 0));
    tick();
    check("axiov_during_load", get_axiov(sel), 0);
    tick();
    while (get_axiov(sel) == 1 && len < nsym + 4) begin
      if (len == poke) drive(sel, 1'b1, 16'($urandom), 1'b1);
      else drive(sel, 1'b0, 16'h0, 1'b0);
      len++;
      tick();
    end
    drive(sel, 1'b0, 16'h0, 1'b0);
    check("frame_length", len, nsym);
    check("busy_after_frame", get_busy(sel), 0);
    check("count_after_frame", get_count(sel), 0);
  endtask

  // Scoreboard monitor: pop and compare on every valid symbol.
  always @(negedge clk) begin
    if (axiov_a) begin
      if (exp_a.size() == 0) check("a_unexpected_symbol", int'(axiod_a), -1);
      else check("a_symbol", int'(axiod_a), exp_a.pop_front());
    end else if (rst) begin
      check("a_idle_axiod", int'(axiod_a), 0);
    end
    if (axiov_b) begin
      if (exp_b.size() == 0) check("b_unexpected_symbol", int'(axiod_b), -1);
      else check("b_symbol", int'(axiod_b), exp_b.pop_front());
    end else if (rst) begin
      check("b_idle_axiod", int'(axiod_b), 0);
    end
  end

  initial begin
    int nsym;
    int sel;
    int nw;
    rst = 1'b0;
    repeat (3) tick();
    for (int s = 0; s < 2; s++) begin
      check("reset_axiov", get_axiov(s), 0);
      check("reset_busy", get_busy(s), 0);
      check("reset_full", get_full(s), 0);
      check("reset_count", get_count(s), 0);
    end
    check("reset_axiod_a", int'(axiod_a), 0);
    rst = 1'b1;
    tick();

    // Basic frame
    write_word(0, 16'h1E4B);
    write_word(0, 16'h8180);
    write_word(0, 16'h0001);
    start_send(0, 1'b0, 16'h0, nsym);
    check_frame(0, nsym, -1);

    // Request on an empty buffer
    start_send(0, 1'b0, 16'h0, nsym);
    check_frame(0, nsym, -1);

    // Write and request on the same edge
    start_send(0, 1'b1, 16'h1234, nsym);
    check_frame(0, nsym, -1);

    // Write and request during a 2-word send are ignored
    write_word(0, 16'($urandom));
    write_word(0, 16'($urandom));
    start_send(0, 1'b0, 16'h0, nsym);
    check_frame(0, nsym, 3);

    // Long ramp
    for (int i = 0; i < 200; i++) write_word(0, 16'(i));
    start_send(0, 1'b0, 16'h0, nsym);
    check_frame(0, nsym, -1);

    // Overflow on the small buffer (N=2)
    for (int i = 0; i < 10; i++) write_word(1, 16'hA000 + 16'(i));
    start_send(1, 1'b0, 16'h0, nsym);
    check_frame(1, nsym, -1);

    // N=2 symbol order
    write_word(1, 16'hC5A3);
    start_send(1, 1'b0, 16'h0, nsym);
    check_frame(1, nsym, -1);

    // Reset five symbols into a frame
    for (int i = 0; i < 10; i++) write_word(0, 16'($urandom));
    start_send(0, 1'b0, 16'h0, nsym);
    repeat (6) tick();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async_reset_axiov", int'(axiov_a), 0);
    check("async_reset_count", int'(count_a), 0);
    check("async_reset_busy", int'(busy_a), 0);
    check("async_reset_axiod", int'(axiod_a), 0);
    exp_a.delete();
    store_a.delete();
    tick();
    rst = 1'b1;
    tick();
    check("post_reset_axiov", int'(axiov_a), 0);

    // Randomized frames on both instances
    repeat (8) begin
      sel = $urandom_range(1, 0);
      nw = (sel == 1) ? $urandom_range(12, 1) : $urandom_range(40, 1);
      for (int i = 0; i < nw; i++) begin
        if ($urandom_range(1, 0) == 1) tick();
        write_word(sel, 16'($urandom));
      end
      start_send(sel, 1'($urandom_range(1, 0)), 16'($urandom), nsym);
      check_frame(sel, nsym, -1);
    end

    tick();
    check("a_leftover_expected", exp_a.size(), 0);
    check("b_leftover_expected", exp_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_store_tx.md
# data_store_tx

Transmit-side word buffer for the nibble-serial link. It accepts 16-bit words from the local datapath and stores them in an internal memory. On a send request it replays the whole stored frame as a contiguous stream of N-bit symbols on `axiod`/`axiov`, most significant symbol first. It mirrors the receive-side store, so a frame written here and received there comes back as the same 16-bit word sequence.

## Interface
- `N`, 4, symbol width in bits; legal values 2, 4, 8 (must divide 16)
- `DEPTH`, 256, word capacity of the buffer; power of two
- `clk`  in  1  system clock (25 MHz on the board)
- `rst`  in  1  asynchronous, active-low reset
- `wr_data`  in  16  word to store
- `wr_valid`  in  1  store `wr_data` this cycle
- `send_request`  in  1  level or pulse; start transmitting the stored frame
- `axiov`  out  1  `axiod` holds a valid symbol
- `axiod`  out  N  output symbol
- `busy`  out  1  transmission in progress (state ≠ FILL)
- `full`  out  1  buffer holds `DEPTH` words
- `count`  out  $clog2(DEPTH+1)  number of words currently stored

## Operation
- States:
  - FILL: accept words.
  - LOAD: one-cycle memory read of word 0.
  - SEND: shift symbols out.
  - FILL is the reset state.
- Writing (FILL only):
  - `wr_valid` with `count < DEPTH` writes `wr_data` at address `count`, then `count` increments.
  - With `full=1` the write is dropped silently.
  - Writes in LOAD or SEND are ignored.
- Starting a send:
  - In FILL, `send_request=1` with a post-write `count > 0` moves to LOAD.
  - A write in the same cycle is accepted and included in the frame.
  - `send_request` with `count==0` is ignored and the block stays in FILL.
- Symbol order:
  - Each word is emitted as 16/N symbols, bits [15:16-N] first and bits [N-1:0] last.
  - Words go out in write order, from address 0 to `count-1`.
- Streaming:
  - SEND keeps `axiov` high with no gaps for exactly `count*16/N` cycles.
  - The next word is prefetched so that word boundaries produce no bubble.
- End of frame:
  - After the last symbol, the block returns to FILL; `count` clears to 0 and `axiov` drops.
  - `send_request` is ignored while `busy=1`; a held level does not retrigger until the return to FILL.
  - Re-sending the same frame requires rewriting it.
- Internal counters:
  - Symbol index within the word: 0..16/N-1, wraps to 0 and advances the word address.
  - Word address: 0..DEPTH-1.
  - Last-symbol detection: (word address == `count-1`) && (symbol index == 16/N-1).
- Memory: inferred single-port-write / single-port-read, registered read (1-cycle latency).

## Timing
- Reset: while `rst=0`, independent of `clk`, the block forces:
  - state = FILL
  - `axiov=0`, `axiod=0`, `busy=0`, `full=0`, `count=0`
  - all pointers = 0
- Reset during SEND aborts the frame immediately and discards its contents.
- Write: `count`/`full` update on the edge that samples `wr_valid`.
- Send latency:
  - `send_request` sampled on edge k → `busy=1` after edge k.
  - First symbol on `axiod` with `axiov=1` after edge k+2.
  - Last symbol after edge k+1+`count*16/N`.
  - `axiov=0`, `busy=0`, `count=0` after the following edge.
- `axiod` is 0 whenever `axiov=0`.
- Outputs are registered; there is no combinational path from inputs to `axiov`/`axiod`.

## Test plan
- Basic frame:
  - Stimulus: N=4; write 0x1E4B, 0x8180, 0x0001; pulse `send_request`.
  - Required: after edge k+2, `axiov` is high for exactly 12 cycles with symbols 1,E,4,B,8,1,8,0,0,0,0,1. Then `axiov=0`, `busy=0`, `count=0`.
- Long ramp:
  - Stimulus: write words 0..199, then send.
  - Required: 800 contiguous valid cycles; each group of 4 symbols reassembles to 0x0000..0x00C7 in order; no gap at any word boundary.
- Full and overflow:
  - Stimulus: DEPTH=8; write 10 words 0xA000+i.
  - Required: `full=1` and `count=8` after the 8th write; send yields only 0xA000..0xA007.
- Ignored requests:
  - Stimulus: `send_request` with an empty buffer; then, during a 2-word send, assert `wr_valid` and `send_request` again.
  - Required: no `axiov` for the empty request; the in-flight send emits exactly 2 words; `count=0` afterwards.
- Same-cycle write and send:
  - Stimulus: write 0x1234 and assert `send_request` on the same edge with `count=0`.
  - Required: symbols 1,2,3,4 are transmitted.
- Reset mid-send and N=2:
  - Stimulus: drop `rst` 5 cycles into a frame; then, with N=2, send 0xC5A3.
  - Required: after the reset, `axiov=0` and `count=0` asynchronously. With N=2, the symbols are 3,0,1,1,2,2,0,3.
